// File: rtl/paralelo_serial_pkg.sv
// rtl/paralelo_serial_pkg.sv - shared types and constants for the paralelo_serial scheduler
//
// Purpose : state encoding, idle/tag symbols and the grant index width helper.
// Ports   : none (package).
// Macro   : PS_SCHED_TAG_EN selects whether the TAG state is used by the scheduler.

package paralelo_serial_pkg;

    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,
        ST_IDLE = 2'd1,
        ST_TAG  = 2'd2,
        ST_SEND = 2'd3
    } sched_state_e;

    localparam logic [7:0] IDLE_SYM_DEFAULT = 8'hBC;
    localparam logic [3:0] TAG_PREFIX       = 4'hF;

    // Width of an index able to address n items; never narrower than one bit.
    function automatic int grant_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational rotating-priority picker
//
// Purpose : returns the first asserted request at or after (last_grant+1) mod N_REQ.
// Ports   : req_valid  [N_REQ-1:0] in  - pending requests
//           last_grant [GW-1:0]    in  - most recently served requester
//           next_idx   [GW-1:0]    out - selected requester (0 when none)
//           any                    out - at least one request pending

module rr_arbiter
    import paralelo_serial_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int GW    = grant_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [GW-1:0]    last_grant,
    output logic [GW-1:0]    next_idx,
    output logic             any
);

    always_comb begin
        int cand;
        cand     = 0;
        next_idx = '0;
        any      = 1'b0;
        // Walk the requesters in rotated order; the first hit wins.
        for (int k = 0; k < N_REQ; k++) begin
            cand = (int'(last_grant) + 1 + k) % N_REQ;
            if (!any && req_valid[GW'(cand)]) begin
                any      = 1'b1;
                next_idx = GW'(cand);
            end
        end
    end

endmodule

// File: rtl/paralelo_serial_scheduler.sv
// rtl/paralelo_serial_scheduler.sv - round-robin byte scheduler feeding the paralelo_serial serializer
//
// Purpose : after reset emits SYNC_LEN idle symbols, then grants bursts of up to
//           BURST_MAX bytes to N_REQ requesters in rotating order.
// Ports   : clk_4f, reset (sync, active-high)
//           req_valid [N_REQ-1:0] in, req_data [8*N_REQ-1:0] in, req_ready [N_REQ-1:0] out
//           ser_valid, ser_data [7:0] out (registered, to serializer valid_in/data_in)
//           grant_id [GW-1:0] out (current or last grant), busy out (state != IDLE)
// Macro   : PS_SCHED_TAG_EN - when defined each burst is preceded by header byte F0|grant_id.

module paralelo_serial_scheduler
    import paralelo_serial_pkg::*;
#(
    parameter  int         N_REQ     = 4,
    parameter  int         BURST_MAX = 4,
    parameter  int         SYNC_LEN  = 4,
    parameter  logic [7:0] IDLE_SYM  = IDLE_SYM_DEFAULT,
    localparam int         GW        = grant_w(N_REQ)
) (
    input  logic                 clk_4f,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 ser_valid,
    output logic [7:0]           ser_data,
    output logic [GW-1:0]        grant_id,
    output logic                 busy
);

    localparam int SW = grant_w(SYNC_LEN);

    sched_state_e  state_q, state_d;
    logic [SW-1:0] sync_cnt_q, sync_cnt_d;
    logic [3:0]    burst_cnt_q, burst_cnt_d;
    logic          ser_valid_q, ser_valid_d;
    logic [7:0]    ser_data_q, ser_data_d;
    logic [GW-1:0] grant_id_q, grant_id_d;
    logic [GW-1:0] last_grant_q, last_grant_d;

    logic [GW-1:0] arb_idx;
    logic          arb_any;
    logic          handshake;
    logic [7:0]    sel_data;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req_valid  (req_valid),
        .last_grant (last_grant_q),
        .next_idx   (arb_idx),
        .any        (arb_any)
    );

    // Byte from the granted requester's slice.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_id_q == GW'(i)) begin
                sel_data = req_data[i*8 +: 8];
            end
        end
    end

    // req_ready is decoded from registered state only, so it never depends on req_valid.
    always_comb begin
        req_ready = '0;
        if (state_q == ST_SEND) begin
            req_ready[grant_id_q] = 1'b1;
        end
    end

    assign handshake = (state_q == ST_SEND) && req_valid[grant_id_q];

    always_comb begin
        state_d      = state_q;
        sync_cnt_d   = sync_cnt_q;
        burst_cnt_d  = burst_cnt_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        ser_valid_d  = 1'b0;
        ser_data_d   = IDLE_SYM;

        case (state_q)
            ST_SYNC: begin
                sync_cnt_d = sync_cnt_q + 1'b1;
                if (sync_cnt_q == SW'(SYNC_LEN - 1)) begin
                    sync_cnt_d = '0;
                    state_d    = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (arb_any) begin
                    grant_id_d  = arb_idx;
                    burst_cnt_d = '0;
`ifdef PS_SCHED_TAG_EN
                    state_d     = ST_TAG;
`else
                    state_d     = ST_SEND;
`endif
                end
            end
`ifdef PS_SCHED_TAG_EN
            ST_TAG: begin
                ser_valid_d = 1'b1;
                ser_data_d  = {TAG_PREFIX, 4'(grant_id_q)};
                state_d     = ST_SEND;
            end
`endif
            ST_SEND: begin
                if (handshake) begin
                    ser_valid_d = 1'b1;
                    ser_data_d  = sel_data;
                    burst_cnt_d = burst_cnt_q + 4'd1;
                    if (burst_cnt_q == 4'(BURST_MAX - 1)) begin
                        state_d      = ST_IDLE;
                        last_grant_d = grant_id_q;
                    end
                end else begin
                    // A missed handshake closes the burst, even with zero bytes sent.
                    state_d      = ST_IDLE;
                    last_grant_d = grant_id_q;
                end
            end
            default: begin
                state_d = ST_SYNC;
            end
        endcase
    end

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            state_q      <= ST_SYNC;
            sync_cnt_q   <= '0;
            burst_cnt_q  <= '0;
            ser_valid_q  <= 1'b0;
            ser_data_q   <= IDLE_SYM;
            grant_id_q   <= '0;
            // Pointing at the last requester gives requester 0 first priority.
            last_grant_q <= GW'(N_REQ - 1);
        end else begin
            state_q      <= state_d;
            sync_cnt_q   <= sync_cnt_d;
            burst_cnt_q  <= burst_cnt_d;
            ser_valid_q  <= ser_valid_d;
            ser_data_q   <= ser_data_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign ser_valid = ser_valid_q;
    assign ser_data  = ser_data_q;
    assign grant_id  = grant_id_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_paralelo_serial_scheduler.sv
// tb/tb_paralelo_serial_scheduler.sv - self-checking bench for paralelo_serial_scheduler

module tb_paralelo_serial_scheduler;

    logic        clk_4f = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        ser_valid;
    logic [7:0]  ser_data;
    logic [1:0]  grant_id;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_4f = ~clk_4f;

    paralelo_serial_scheduler dut (
        .clk_4f    (clk_4f),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .ser_valid (ser_valid),
        .ser_data  (ser_data),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  rv;
        logic [31:0] rd;
        logic        sv;
        logic [7:0]  sd;
        logic [3:0]  rdy;
        logic [1:0]  gid;
        logic        bsy;
    } vec_t;

    vec_t vt[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic step();
        @(posedge clk_4f);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = 4'h0;
        req_data  = 32'h0;
        step();
        step();
        check("rst_ser_valid", 32'(ser_valid), 32'h0);
        check("rst_ser_data",  32'(ser_data),  32'hBC);
        check("rst_busy",      32'(busy),      32'h1);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("sync_ready", 32'(req_ready), 32'h0);
            check("sync_valid", 32'(ser_valid), 32'h0);
        end
        check("sync_done_idle", 32'(busy), 32'h0);
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 4'h0;
        req_data  = 32'h0;
        #1;

`ifdef PS_SCHED_TAG_EN
        do_reset();
        req_valid = 4'b1000;
        req_data  = 32'hCC00_0000;
        step();
        check("tag_arb_valid", 32'(ser_valid), 32'h0);
        step();
        check("tag_valid", 32'(ser_valid), 32'h1);
        check("tag_byte",  32'(ser_data),  32'hF3);
        step();
        check("tag_data_valid", 32'(ser_valid), 32'h1);
        check("tag_data",       32'(ser_data),  32'hCC);
`else
        // Reset, sync preamble and a single burst from requester 2.
        vt[0]  = '{1'b1, 4'h0, 32'h0000_0000, 1'b0, 8'hBC, 4'h0, 2'd0, 1'b1};
        vt[1]  = '{1'b1, 4'h0, 32'h0000_0000, 1'b0, 8'hBC, 4'h0, 2'd0, 1'b1};
        vt[2]  = '{1'b0, 4'hF, 32'h0000_0000, 1'b0, 8'hBC, 4'h0, 2'd0, 1'b1};
        vt[3]  = '{1'b0, 4'hF, 32'h0000_0000, 1'b0, 8'hBC, 4'h0, 2'd0, 1'b1};
        vt[4]  = '{1'b0, 4'hF, 32'h0000_0000, 1'b0, 8'hBC, 4'h0, 2'd0, 1'b1};
        vt[5]  = '{1'b0, 4'hF, 32'h0000_0000, 1'b0, 8'hBC, 4'h0, 2'd0, 1'b0};
        vt[6]  = '{1'b0, 4'h4, 32'h0011_0000, 1'b0, 8'hBC, 4'h4, 2'd2, 1'b1};
        vt[7]  = '{1'b0, 4'h4, 32'h0011_0000, 1'b1, 8'h11, 4'h4, 2'd2, 1'b1};
        vt[8]  = '{1'b0, 4'h4, 32'h0012_0000, 1'b1, 8'h12, 4'h4, 2'd2, 1'b1};
        vt[9]  = '{1'b0, 4'h4, 32'h0013_0000, 1'b1, 8'h13, 4'h4, 2'd2, 1'b1};
        vt[10] = '{1'b0, 4'h4, 32'h0014_0000, 1'b1, 8'h14, 4'h0, 2'd2, 1'b0};
        vt[11] = '{1'b0, 4'h4, 32'h0015_0000, 1'b0, 8'hBC, 4'h4, 2'd2, 1'b1};
        vt[12] = '{1'b0, 4'h4, 32'h0015_0000, 1'b1, 8'h15, 4'h4, 2'd2, 1'b1};
        vt[13] = '{1'b0, 4'h0, 32'h0000_0000, 1'b0, 8'hBC, 4'h0, 2'd2, 1'b0};
        vt[14] = '{1'b0, 4'h0, 32'h0000_0000, 1'b0, 8'hBC, 4'h0, 2'd2, 1'b0};

        for (int i = 0; i < 15; i++) begin
            reset     = vt[i].rst;
            req_valid = vt[i].rv;
            req_data  = vt[i].rd;
            step();
            check($sformatf("vec%0d_ser_valid", i), 32'(ser_valid), 32'(vt[i].sv));
            check($sformatf("vec%0d_ser_data", i),  32'(ser_data),  32'(vt[i].sd));
            check($sformatf("vec%0d_req_ready", i), 32'(req_ready), 32'(vt[i].rdy));
            check($sformatf("vec%0d_grant_id", i),  32'(grant_id),  32'(vt[i].gid));
            check($sformatf("vec%0d_busy", i),      32'(busy),      32'(vt[i].bsy));
        end

        // Round robin: all four valid, expect grants 0,1,2,3,0 with 4 bytes each.
        do_reset();
        req_valid = 4'hF;
        req_data  = 32'hD3D2_D1D0;
        for (int b = 0; b < 5; b++) begin
            step();
            check($sformatf("rr%0d_gap_valid", b), 32'(ser_valid), 32'h0);
            check($sformatf("rr%0d_grant", b),     32'(grant_id),  32'(b % 4));
            check($sformatf("rr%0d_ready", b),     32'(req_ready), 32'(1 << (b % 4)));
            for (int k = 0; k < 4; k++) begin
                step();
                check($sformatf("rr%0d_b%0d_valid", b, k), 32'(ser_valid), 32'h1);
                check($sformatf("rr%0d_b%0d_data", b, k),  32'(ser_data),  32'hD0 + 32'(b % 4));
            end
        end

        // Early drop: requester 1 sends AA, CC then drops; requester 2 pending is next.
        req_valid = 4'b0110;
        req_data  = 32'h0055_AA00;
        step();
        check("drop_grant", 32'(grant_id), 32'h1);
        step();
        check("drop_b0", 32'(ser_data), 32'hAA);
        req_data = 32'h0055_CC00;
        step();
        check("drop_b1", 32'(ser_data), 32'hCC);
        check("drop_b1_valid", 32'(ser_valid), 32'h1);
        req_valid = 4'b0100;
        step();
        check("drop_end_valid", 32'(ser_valid), 32'h0);
        check("drop_end_busy",  32'(busy),      32'h0);
        step();
        check("drop_next_grant", 32'(grant_id),  32'h2);
        check("drop_next_ready", 32'(req_ready), 32'h4);
        step();
        check("mid_b0", 32'(ser_data), 32'h55);

        // Reset during the second byte of the burst.
        reset = 1'b1;
        step();
        check("midrst_valid", 32'(ser_valid), 32'h0);
        check("midrst_data",  32'(ser_data),  32'hBC);
        check("midrst_ready", 32'(req_ready), 32'h0);
        check("midrst_grant", 32'(grant_id),  32'h0);
        check("midrst_busy",  32'(busy),      32'h1);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("midrst_sync_valid", 32'(ser_valid), 32'h0);
            check("midrst_sync_ready", 32'(req_ready), 32'h0);
        end

        // Zero-byte burst still advances the pointer: last=2 makes 3 win over 0.
        step();
        check("zero_grant", 32'(grant_id), 32'h2);
        req_valid = 4'b0000;
        step();
        check("zero_valid", 32'(ser_valid), 32'h0);
        check("zero_busy",  32'(busy),      32'h0);
        req_valid = 4'b1001;
        step();
        check("zero_next_grant", 32'(grant_id), 32'h3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/paralelo_serial_scheduler.md
# paralelo_serial_scheduler

Round-robin scheduler that shares the single `paralelo_serial` byte serializer among `N_REQ` byte-stream requesters. It runs in the `clk_4f` domain and drives the serializer's `valid_in`/`data_in` pair. It emits a comma sync preamble after reset, then grants bounded bursts per requester. Serializer-side idle is signalled with `valid=0` and `data=IDLE_SYM`.

## Interface
- `N_REQ`, 4: number of requesters; must be 2..8.
- `BURST_MAX`, 4: maximum bytes per grant; must be 1..15.
- `SYNC_LEN`, 4: number of `IDLE_SYM` preamble cycles after reset; must be ≥1.
- `IDLE_SYM`, 8'hBC: byte driven on `ser_data` whenever `ser_valid=0`.
- `clk_4f`, in, 1: byte clock; all logic on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `req_valid`, in, N_REQ: requester i has a byte on its slice.
- `req_data`, in, 8*N_REQ: requester i's byte is `[8i+7:8i]`.
- `req_ready`, out, N_REQ: one-hot or zero; byte i is accepted on a cycle with `req_valid[i] & req_ready[i]`.
- `ser_valid`, out, 1: to serializer `valid_in`; registered.
- `ser_data`, out, 8: to serializer `data_in`; registered.
- `grant_id`, out, clog2(N_REQ): currently or last granted requester; registered.
- `busy`, out, 1: high in every state except IDLE.

## Operation
- Reset values:
  - State SYNC; sync counter 0.
  - `ser_valid=0`, `ser_data=IDLE_SYM`, `req_ready=0`, `grant_id=0`, `busy=1`.
  - Round-robin pointer set so requester 0 has top priority.
- States:
  - **SYNC**: drive idle for `SYNC_LEN` cycles, ignoring requests. Go to IDLE when the counter reaches `SYNC_LEN-1`.
  - **IDLE**: if any `req_valid` is set, pick the first set bit at or after (last_grant+1) mod N_REQ. Load `grant_id`, clear the burst counter, and go to TAG (macro on) or SEND. If no request is set, stay in IDLE.
  - **TAG** (macro only): emit one tag byte with `ser_valid=1`, then go to SEND.
  - **SEND**: `req_ready[grant_id]=1`, combinationally decoded from registered state.
    - Each accepted byte is registered to `ser_data` with `ser_valid=1` and increments the burst counter.
    - A cycle without a handshake registers idle (`ser_valid=0`, `IDLE_SYM`) and ends the burst.
    - After `BURST_MAX` accepted bytes, the burst ends.
    - End of burst returns to IDLE and updates last_grant.
- The scheduler never preempts mid-burst. Requests raised by other requesters wait until the current burst ends.
- `req_data` is sampled only on a handshake. `req_valid` may drop at any time without error.
- A requester that remains valid is granted again only after every other valid requester has been served once.
- `reset` in any state, including mid-burst, aborts immediately:
  - The partial burst is not resumed.
  - Outputs take their reset values on the next edge.
  - The scheduler returns to SYNC.

## Timing
- Handshake to `ser_data`/`ser_valid` latency is 1 cycle.
- Request-to-first-byte latency from IDLE: the first `ser_valid` appears 2 cycles after `req_valid` is first seen in IDLE (3 with the macro on).
- A full burst occupies 1 + `BURST_MAX` cycles (2 + `BURST_MAX` with the macro on), followed by a mandatory IDLE arbitration cycle in which `ser_valid=0`.
- Simultaneous requests are resolved by rotating priority only. There is no fixed priority after the first grant.
- If `req_valid[grant_id]` drops in the first SEND cycle, the burst ends with zero bytes and last_grant still advances.

## Configuration
- Macro `PS_SCHED_TAG_EN`:
  - Defined: TAG state is present. Each burst is preceded by one header byte `8'hF0 | grant_id` with `ser_valid=1`.
  - Undefined: TAG state and its logic are absent, and IDLE goes directly to SEND.

## Structure
- Shared package `paralelo_serial_pkg` holds:
  - The state enum (SYNC, IDLE, TAG, SEND).
  - `IDLE_SYM_DEFAULT` (8'hBC).
  - `TAG_PREFIX` (4'hF).
  - A `clog2`-based `grant_id` width function.
- Sub-module `rr_arbiter`: combinational rotating-priority picker.
  - Inputs: `req_valid` and the last_grant pointer.
  - Outputs: next index and an `any` flag.
- The FSM, counters and output registers stay in the top module.

## Test plan
- **Reset/sync**: hold `reset` 2 cycles, then release with `req_valid=4'b1111` -> `ser_valid=0`, `ser_data=8'hBC` for 4 cycles, and `req_ready=0` throughout.
- **Single burst**: requester 2 continuously valid with bytes 0x11..0x16 -> 0x11..0x14 appear on `ser_data` with `grant_id=2`, then one idle cycle (`ser_valid=0`), then 0x15 in the next burst.
- **Round robin**: all four requesters continuously valid -> grant order 0,1,2,3,0, with 4 bytes per burst.
- **Early drop**: requester 1 sends 0xAA, 0xCC, then drops valid -> burst ends after 2 bytes, and the next grant goes to requester 2 if it is pending.
- **Reset mid-burst**: assert `reset` during the 2nd byte of a burst -> next edge gives `ser_valid=0`, `ser_data=8'hBC`, state SYNC, and the burst is not resumed.
- **Tag (macro on)**: requester 3 sends 0xCC -> `ser_data` shows 0xF3 then 0xCC, both with `ser_valid=1`.
